// File: rtl/psx_bus_receiver.sv
// psx_bus_receiver
//   Passive receiver for the PSX controller bus. Synchronizes ATT#, CLK, CMD and DAT into
//   the clk domain, deserializes LSB-first CMD/DAT bytes on PSX clock rising edges and
//   reports each completed byte pair with its position in the packet. Flags packets that
//   end mid-byte or stall mid-byte.
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   psx_att_n          async packet select (active low)
//   psx_clk            async bus clock (idles high)
//   psx_cmd, psx_dat   async console->pad / pad->console data
//   byte_strobe        one-cycle pulse, cmd_byte/dat_byte/byte_index valid
//   cmd_byte, dat_byte last completed byte pair, held until the next strobe
//   byte_index         position of the strobed byte in the packet (saturating)
//   packet_start/end   one-cycle pulses on ATT# fall / rise
//   frame_error        one-cycle pulse when a partial byte is discarded
//   busy               high while a packet is being shifted in
module psx_bus_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TIMEOUT_WIDTH  = 13,
  parameter int unsigned INDEX_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   psx_att_n,
  input  logic                   psx_clk,
  input  logic                   psx_cmd,
  input  logic                   psx_dat,
  output logic                   byte_strobe,
  output logic [7:0]             cmd_byte,
  output logic [7:0]             dat_byte,
  output logic [INDEX_WIDTH-1:0] byte_index,
  output logic                   packet_start,
  output logic                   packet_end,
  output logic                   frame_error,
  output logic                   busy
);

  localparam logic [TIMEOUT_WIDTH-1:0] TmoLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [INDEX_WIDTH-1:0]   IdxMax  = {INDEX_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StShift, StWaitHigh} state_e;

  // Synchronizers plus edge-detect stage
  logic att_s1_q, att_s2_q, att_s3_q;
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic cmd_s1_q, cmd_s2_q, dat_s1_q, dat_s2_q;
  logic att_rise_q, att_fall_q, att_lvl_q, clk_rise_q, cmd_bit_q, dat_bit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      att_s1_q   <= 1'b1;
      att_s2_q   <= 1'b1;
      att_s3_q   <= 1'b1;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      cmd_s1_q   <= 1'b0;
      cmd_s2_q   <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      att_rise_q <= 1'b0;
      att_fall_q <= 1'b0;
      att_lvl_q  <= 1'b1;
      clk_rise_q <= 1'b0;
      cmd_bit_q  <= 1'b0;
      dat_bit_q  <= 1'b0;
    end else begin
      att_s1_q   <= psx_att_n;
      att_s2_q   <= att_s1_q;
      att_s3_q   <= att_s2_q;
      clk_s1_q   <= psx_clk;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
      cmd_s1_q   <= psx_cmd;
      cmd_s2_q   <= cmd_s1_q;
      dat_s1_q   <= psx_dat;
      dat_s2_q   <= dat_s1_q;
      // Edge flags, level and data are all registered together so they stay aligned
      att_rise_q <= att_s2_q & ~att_s3_q;
      att_fall_q <= ~att_s2_q & att_s3_q;
      att_lvl_q  <= att_s2_q;
      clk_rise_q <= clk_s2_q & ~clk_s3_q;
      cmd_bit_q  <= cmd_s2_q;
      dat_bit_q  <= dat_s2_q;
    end
  end

  // Packet state machine
  state_e                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [7:0]               cmd_sh_q, cmd_sh_d, dat_sh_q, dat_sh_d;
  logic [2:0]               boot_q, boot_d;
  logic                     strobe_q, strobe_d;
  logic                     start_q, start_d;
  logic                     end_q, end_d;
  logic                     fe_q, fe_d;
  logic [7:0]               cmd_byte_q, cmd_byte_d, dat_byte_q, dat_byte_d;
  logic [INDEX_WIDTH-1:0]   byte_index_q, byte_index_d;
  logic                     timeout;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    cmd_sh_d     = cmd_sh_q;
    dat_sh_d     = dat_sh_q;
    boot_d       = boot_q;
    strobe_d     = 1'b0;
    start_d      = 1'b0;
    end_d        = 1'b0;
    fe_d         = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    dat_byte_d   = dat_byte_q;
    byte_index_d = byte_index_q;
    timeout      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!boot_q[2]) begin
          // Edge flags are bogus until the pipeline has refilled after reset; decide
          // on the settled ATT# level instead so a packet is never joined mid-stream.
          boot_d = boot_q + 3'd1;
          if (boot_q == 3'd3 && !att_lvl_q) begin
            state_d = StWaitHigh;
          end
        end else if (att_fall_q) begin
          state_d   = StShift;
          start_d   = 1'b1;
          bit_cnt_d = '0;
          idx_d     = '0;
          tmo_d     = '0;
        end
      end

      StShift: begin
        if (clk_rise_q) begin
          cmd_sh_d = {cmd_bit_q, cmd_sh_q[7:1]};
          dat_sh_d = {dat_bit_q, dat_sh_q[7:1]};
          tmo_d    = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d    = '0;
            strobe_d     = 1'b1;
            cmd_byte_d   = cmd_sh_d;
            dat_byte_d   = dat_sh_d;
            byte_index_d = idx_q;
            if (idx_q != IdxMax) begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (bit_cnt_q != 3'd0) begin
          if (tmo_q == TmoLast) begin
            timeout = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end

        // bit_cnt_d already accounts for a bit completing in this same cycle
        if (att_rise_q) begin
          end_d     = 1'b1;
          fe_d      = (bit_cnt_d != 3'd0);
          bit_cnt_d = '0;
          state_d   = StIdle;
        end else if (timeout) begin
          fe_d      = 1'b1;
          bit_cnt_d = '0;
          tmo_d     = '0;
          state_d   = StWaitHigh;
        end
      end

      StWaitHigh: begin
        if (att_lvl_q) begin
          end_d   = att_rise_q;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      cmd_sh_q     <= '0;
      dat_sh_q     <= '0;
      boot_q       <= '0;
      strobe_q     <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      fe_q         <= 1'b0;
      cmd_byte_q   <= 8'h00;
      dat_byte_q   <= 8'h00;
      byte_index_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      cmd_sh_q     <= cmd_sh_d;
      dat_sh_q     <= dat_sh_d;
      boot_q       <= boot_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      end_q        <= end_d;
      fe_q         <= fe_d;
      cmd_byte_q   <= cmd_byte_d;
      dat_byte_q   <= dat_byte_d;
      byte_index_q <= byte_index_d;
    end
  end

  assign byte_strobe  = strobe_q;
  assign cmd_byte     = cmd_byte_q;
  assign dat_byte     = dat_byte_q;
  assign byte_index   = byte_index_q;
  assign packet_start = start_q;
  assign packet_end   = end_q;
  assign frame_error  = fe_q;
  assign busy         = (state_q == StShift);

endmodule
